// File: rtl/cpu_types.sv
// Shared CPU-side types for run control.
// CpuError flag bundle and RunState encoding.
package cpu_types;

  typedef struct packed {
    logic decoder;
    logic alu;
  } CpuError;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DRAIN,
    HALTED,
    FAULT
  } RunState;

  function automatic logic any_error(
    input CpuError e
  );
    return e.decoder | e.alu;
  endfunction

endpackage

// File: rtl/run_controller.sv
// Run sequencer: holds the CPU in reset, runs it, counts cycles, latches halt/fault.
// Ports: clk, reset(async low), start, step_mode, step, cpu_stop, cpu_error -> cpu_reset, cpu_clk_en, halted, fault, fault_code, cycle_count.
module run_controller
  import cpu_types::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             cpu_stop,
  input  CpuError          cpu_error,
  output logic             cpu_reset,
  output logic             cpu_clk_en,
  output logic             halted,
  output logic             fault,
  output CpuError          fault_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned RW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RW-1:0] HOLD_LOAD =
    RW'(RESET_CYCLES - 1);

  RunState       state_q;
  RunState       state_d;
  logic [RW-1:0] hold_q;
  logic          step_mode_q;
  logic          launch;
  logic          run_en;
  logic          count_en;
  logic          err_hit;

  assign launch = (state_q == IDLE) && start;

  // In step mode the CPU only advances on a step pulse;
  // exits are judged on those same cycles.
  assign run_en = (state_q == RUN) &&
                  (!step_mode_q || step);

  assign err_hit = run_en && any_error(cpu_error);

  assign count_en = run_en || (state_q == DRAIN);

  assign cpu_clk_en = (state_q == RESET) ||
                      (state_q == DRAIN) ||
                      run_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RESET;
      end
      RESET: begin
        if (hold_q == '0) state_d = RUN;
      end
      RUN: begin
        if (err_hit) begin
          state_d = FAULT;
        end else if (run_en && cpu_stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = HALTED;
      end
      HALTED, FAULT: begin
        if (!start) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cpu_reset <= 1'b1;
    end else begin
      state_q   <= state_d;
      cpu_reset <= (state_d == IDLE) ||
                   (state_d == RESET);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_mode_q <= 1'b0;
    end else if (state_q == IDLE) begin
      step_mode_q <= step_mode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (launch) begin
      hold_q <= HOLD_LOAD;
    end else if ((state_q == RESET) &&
                 (hold_q != '0)) begin
      hold_q <= hold_q - RW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (launch) begin
      cycle_count <= '0;
    end else if (count_en) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= '0;
    end else if (launch) begin
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= '0;
    end else begin
      if (state_q == DRAIN) halted <= 1'b1;
      if (err_hit) begin
        fault      <= 1'b1;
        fault_code <= cpu_error;
      end
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller.
// Stimulus queues expected snapshots; monitor compares on run end or snap.
module tb_run_controller;
  import cpu_types::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        step_mode;
  logic        step;
  logic        cpu_stop;
  CpuError     cpu_error;
  logic        cpu_reset;
  logic        cpu_clk_en;
  logic        halted;
  logic        fault;
  CpuError     fault_code;
  logic [31:0] cycle_count;

  run_controller #(
    .RESET_CYCLES(4),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .step_mode(step_mode),
    .step(step),
    .cpu_stop(cpu_stop),
    .cpu_error(cpu_error),
    .cpu_reset(cpu_reset),
    .cpu_clk_en(cpu_clk_en),
    .halted(halted),
    .fault(fault),
    .fault_code(fault_code),
    .cycle_count(cycle_count)
  );

  typedef struct {
    string name;
    int    h;
    int    f;
    int    code;
    int    cnt;
    int    rst;
    int    ren;
    int    crst;
    int    en;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs    = 0;
  logic snap    = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    if (exp >= 0) begin
      vectors++;
      if (act != exp) begin
        errs++;
        $display("FAIL %s: got %0d expected %0d",
                 name, act, exp);
      end
    end
  endtask

  function automatic exp_t mk(
    input string name, input int h, input int f,
    input int code, input int cnt, input int rst,
    input int ren, input int crst, input int en);
    exp_t e;
    e.name = name; e.h = h; e.f = f;
    e.code = code; e.cnt = cnt; e.rst = rst;
    e.ren = ren; e.crst = crst; e.en = en;
    return e;
  endfunction

  // Monitor: tracks reset-hold and run enable cycles per run.
  initial begin
    int   rc = 0;
    int   rn = 0;
    logic prev_end = 1'b0;
    logic ev;
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_reset && !cpu_clk_en) begin
        rc = 0;
        rn = 0;
      end else if (cpu_clk_en) begin
        if (cpu_reset) rc++;
        else rn++;
      end
      ev = snap || ((halted || fault) && !prev_end);
      prev_end = halted || fault;
      if (ev) begin
        if (q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL unexpected_output: h=%0d f=%0d",
                   halted, fault);
        end else begin
          e = q.pop_front();
          chk({e.name, ".halted"}, int'(halted), e.h);
          chk({e.name, ".fault"}, int'(fault), e.f);
          chk({e.name, ".code"}, int'(fault_code), e.code);
          chk({e.name, ".count"}, int'(cycle_count), e.cnt);
          chk({e.name, ".rst_cyc"}, rc, e.rst);
          chk({e.name, ".run_en"}, rn, e.ren);
          chk({e.name, ".cpu_reset"}, int'(cpu_reset), e.crst);
          chk({e.name, ".clk_en"}, int'(cpu_clk_en), e.en);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot(input exp_t e);
    q.push_back(e);
    snap = 1'b1;
    @(negedge clk);
    #1;
    snap = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (cpu_reset && n < 40) begin
      cyc();
      n++;
    end
    if (cpu_reset) begin
      vectors++;
      errs++;
      $display("FAIL wait_run: got timeout expected RUN");
    end
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(halted || fault) && n < 60) begin
      cyc();
      n++;
    end
    if (!(halted || fault)) begin
      vectors++;
      errs++;
      $display("FAIL wait_end: got timeout expected end");
    end
    cyc();
  endtask

  task automatic finish_run();
    wait_end();
    start = 1'b0;
    repeat (2) cyc();
  endtask

  // Drive stop/error on RUN cycle k, counting from the current cycle as 1.
  task automatic at_cycle(input int k, input logic s,
                          input logic [1:0] err);
    repeat (k - 1) cyc();
    cpu_stop  = s;
    cpu_error = err;
    cyc();
    cpu_stop  = 1'b0;
    cpu_error = '0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    cpu_stop  = 1'b0;
    cpu_error = '0;
    #2 reset = 1'b0;
    snapshot(mk("reset", 0, 0, 0, 0, -1, -1, 1, 0));
    cyc();
    reset = 1'b1;
    cyc();

    // Free run, EBREAK on cycle 10
    start = 1'b1;
    wait_run();
    q.push_back(mk("free", 1, 0, 0, 11, 4, 11, 0, 0));
    at_cycle(10, 1'b1, 2'b00);
    finish_run();

    // Rerun clears flags, counts from zero
    start = 1'b1;
    wait_run();
    snapshot(mk("rerun_c1", 0, 0, 0, 0, 4, 1, 0, 1));
    q.push_back(mk("rerun", 1, 0, 0, 5, 4, 5, 0, 0));
    at_cycle(4, 1'b1, 2'b00);
    finish_run();

    // Decoder error masked in RESET, taken on RUN cycle 3
    start     = 1'b1;
    cpu_error = 2'b10;
    wait_run();
    cpu_error = '0;
    q.push_back(mk("dec_err", 0, 1, 2, 3, 4, 3, 0, 0));
    at_cycle(3, 1'b0, 2'b10);
    wait_end();
    cpu_error = 2'b01;
    repeat (3) cyc();
    snapshot(mk("frozen", 0, 1, 2, 3, 4, 3, 0, 0));
    cpu_error = '0;
    start = 1'b0;
    repeat (2) cyc();

    // Stop and ALU error together: error wins
    start = 1'b1;
    wait_run();
    q.push_back(mk("prio", 0, 1, 1, 2, 4, 2, 0, 0));
    at_cycle(2, 1'b1, 2'b01);
    finish_run();

    // Step mode; step_mode dropped mid-run must not matter
    step_mode = 1'b1;
    start     = 1'b1;
    wait_run();
    step_mode = 1'b0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      if (p < 2) repeat (4) cyc();
    end
    snapshot(mk("step3", 0, 0, 0, 3, 4, 3, 0, 0));
    cpu_stop = 1'b1;
    cyc();
    cpu_stop = 1'b0;
    cyc();
    q.push_back(mk("step_end", 1, 0, 0, 5, 4, 5, 0, 0));
    step     = 1'b1;
    cpu_stop = 1'b1;
    cyc();
    step     = 1'b0;
    cpu_stop = 1'b0;
    finish_run();

    // Async reset mid-run
    start = 1'b1;
    wait_run();
    repeat (5) cyc();
    reset = 1'b0;
    #1;
    chk("async_immediate.cpu_reset", int'(cpu_reset), 1);
    chk("async_immediate.count", int'(cycle_count), 0);
    snapshot(mk("async", 0, 0, 0, 0, -1, -1, 1, 0));
    start = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    snapshot(mk("post_async", 0, 0, 0, 0, -1, -1, 1, 0));

    repeat (3) cyc();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
